// File: rtl/xswitch_pkg.sv
// Shared switch definitions: port count, default field widths and receive FSM state type.
// Used by every xswitch receive-side module through import xswitch_pkg::*.
package xswitch_pkg;

  localparam int XSW_NUM_PORTS = 4;
  localparam int XSW_DATA_W    = 8;
  localparam int XSW_ADDR_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

  // Saturating increment for 8-bit event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/xswitch_rx_fifo.sv
// Receive FIFO for one switch port: DEPTH entries (power of two), pointers wrap naturally.
// The head entry reads as zero while the FIFO is empty.
module xswitch_rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // full is taken from the registered count, so a push at full is refused even alongside a pop
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // NOTE: the storage array is deliberately not reset; gating rdata with empty makes stale contents invisible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/xswitch_rx_port.sv
// Switch output-port receiver: two-state IDLE/ACK handshake feeding a local FIFO.
// Optional macro XSWITCH_RX_ADDR_CHECK_EN drops and counts words not addressed to PORT_ID.
module xswitch_rx_port
  import xswitch_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DATA_W  = XSW_DATA_W,
  parameter int ADDR_W  = XSW_ADDR_W,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_out,
  input  logic [DATA_W-1:0]      data_out,
  input  logic [ADDR_W-1:0]      addr_out,
  output logic                   data_rd,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             err_cnt
);

  if (PORT_ID < 0 || PORT_ID >= XSW_NUM_PORTS || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("xswitch_rx_port: PORT_ID must be 0..3 and DEPTH a power of two >= 2");
  end

  rx_state_t                  state;
  logic                       accept;
  logic                       addr_ok;
  logic                       push;
  logic [ADDR_W+DATA_W-1:0]   head;

  // The switch holds its word until data_rd, so capture needs no holding register.
  assign accept = (state == IDLE) & valid_out & ~full;
  assign push   = accept & addr_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= accept ? ACK : IDLE;
  end

  // The state flop itself is the registered acknowledge.
  assign data_rd = (state == ACK);

`ifdef XSWITCH_RX_ADDR_CHECK_EN
  assign addr_ok = (addr_out == ADDR_W'(PORT_ID));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 err_cnt <= 8'd0;
    else if (accept && !addr_ok) err_cnt <= sat_inc8(err_cnt);
  end
`else
  assign addr_ok = 1'b1;
  assign err_cnt = 8'd0;
`endif

  xswitch_rx_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_out, data_out}),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign {rd_addr, rd_data} = head;

endmodule

// File: tb/tb_xswitch_rx_port.sv
// Self-checking bench for xswitch_rx_port: directed handshake/FIFO scenarios plus random
// traffic checked every cycle against a queue-based reference model.
module tb_xswitch_rx_port;

  localparam int PORT_ID = 2;
  localparam int DEPTH   = 4;

  logic                   clk       = 1'b0;
  logic                   reset     = 1'b1;
  logic                   valid_out = 1'b0;
  logic [7:0]             data_out  = 8'h00;
  logic [7:0]             addr_out  = 8'h00;
  logic                   pop       = 1'b0;
  logic                   data_rd;
  logic [7:0]             rd_data;
  logic [7:0]             rd_addr;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]             err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: stored words as {addr,data}, pending acknowledge, error count.
  logic [15:0] mq[$];
  bit          m_ack;
  int          m_err;

  always #5 clk = ~clk;

  xswitch_rx_port #(
    .PORT_ID (PORT_ID),
    .DATA_W  (8),
    .ADDR_W  (8),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_out (valid_out),
    .data_out  (data_out),
    .addr_out  (addr_out),
    .data_rd   (data_rd),
    .pop       (pop),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] head;
    head = (mq.size() > 0) ? mq[0] : 16'h0000;
    check({tag, ".data_rd"}, 32'(data_rd), 32'(m_ack));
    check({tag, ".count"},   32'(count),   32'(mq.size()));
    check({tag, ".empty"},   32'(empty),   32'(mq.size() == 0));
    check({tag, ".full"},    32'(full),    32'(mq.size() == DEPTH));
    check({tag, ".rd_data"}, 32'(rd_data), 32'(head[7:0]));
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'(head[15:8]));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare everything.
  task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                       input logic [7:0] a, input logic p);
    bit acc, pop_ok, match;
    valid_out = v;
    data_out  = d;
    addr_out  = a;
    pop       = p;
    acc    = !m_ack && v && (mq.size() < DEPTH);
    pop_ok = p && (mq.size() > 0);
`ifdef XSWITCH_RX_ADDR_CHECK_EN
    match = (a == 8'(PORT_ID));
`else
    match = 1'b1;
`endif
    @(posedge clk);
    #1;
    if (pop_ok) void'(mq.pop_front());
    if (acc && match) mq.push_back({a, d});
    if (acc && !match && m_err < 255) m_err++;
    m_ack = acc;
    check_model(tag);
  endtask

  // Asynchronous reset assertion away from the clock edge; released on the next falling edge.
  task automatic do_reset(input string tag);
    reset     = 1'b0;
    valid_out = 1'b0;
    pop       = 1'b0;
    #1;
    mq.delete();
    m_ack = 1'b0;
    m_err = 0;
    check_model(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit          have;
    logic [7:0]  hd, ha;

    #2;
    do_reset("rst");
    check("rst.rd_data_zero", 32'(rd_data), 32'h0);
    check("rst.empty", 32'(empty), 32'h1);

    // First capture on the first edge after release; acknowledge visible for exactly one cycle.
    check("first.pre_ack", 32'(data_rd), 32'h0);
    cycle("first.e1", 1'b1, 8'hA5, 8'(PORT_ID), 1'b0);
    check("first.ack", 32'(data_rd), 32'h1);
    check("first.rd_data", 32'(rd_data), 32'hA5);
    check("first.count", 32'(count), 32'h1);
    cycle("first.e2", 1'b1, 8'hA5, 8'(PORT_ID), 1'b0);
    check("first.ack_drop", 32'(data_rd), 32'h0);
    cycle("first.idle", 1'b0, 8'h00, 8'h00, 1'b0);

    // Fill to full, then backpressure a fifth word until a pop frees a slot.
    do_reset("bp.rst");
    for (int k = 0; k < DEPTH; k++) begin
      cycle("bp.fill", 1'b1, 8'(8'h10 + k), 8'(PORT_ID), 1'b0);
      cycle("bp.fill", 1'b1, 8'(8'h10 + k), 8'(PORT_ID), 1'b0);
    end
    check("bp.full", 32'(full), 32'h1);
    for (int k = 0; k < 3; k++) begin
      cycle("bp.hold", 1'b1, 8'h55, 8'(PORT_ID), 1'b0);
      check("bp.no_ack", 32'(data_rd), 32'h0);
    end
    cycle("bp.pop_at_full", 1'b1, 8'h55, 8'(PORT_ID), 1'b1);
    check("bp.refused_with_pop", 32'(data_rd), 32'h0);
    check("bp.count3", 32'(count), 32'h3);
    cycle("bp.accept", 1'b1, 8'h55, 8'(PORT_ID), 1'b0);
    check("bp.ack", 32'(data_rd), 32'h1);
    check("bp.count4", 32'(count), 32'h4);
    cycle("bp.ackcyc", 1'b1, 8'h55, 8'(PORT_ID), 1'b0);
    for (int k = 0; k < DEPTH + 1; k++) cycle("bp.drain", 1'b0, 8'h00, 8'h00, 1'b1);

    // Simultaneous push and pop at count=2 keeps the count and the order.
    do_reset("pp.rst");
    cycle("pp.w1", 1'b1, 8'h21, 8'(PORT_ID), 1'b0);
    cycle("pp.w1", 1'b1, 8'h21, 8'(PORT_ID), 1'b0);
    cycle("pp.w2", 1'b1, 8'h22, 8'(PORT_ID), 1'b0);
    cycle("pp.w2", 1'b1, 8'h22, 8'(PORT_ID), 1'b0);
    cycle("pp.both", 1'b1, 8'h23, 8'(PORT_ID), 1'b1);
    check("pp.count2", 32'(count), 32'h2);
    check("pp.head", 32'(rd_data), 32'h22);
    cycle("pp.ack", 1'b0, 8'h00, 8'h00, 1'b1);
    check("pp.last", 32'(rd_data), 32'h23);
    cycle("pp.drain", 1'b0, 8'h00, 8'h00, 1'b1);

    // Pop on an empty FIFO is ignored; the next word lands at the head.
    do_reset("pe.rst");
    for (int k = 0; k < 3; k++) cycle("pe.pop", 1'b0, 8'h00, 8'h00, 1'b1);
    check("pe.count0", 32'(count), 32'h0);
    cycle("pe.w", 1'b1, 8'h3C, 8'(PORT_ID), 1'b1);
    check("pe.head", 32'(rd_data), 32'h3C);
    cycle("pe.ack", 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset during the ACK cycle discards the captured word and drops data_rd at once.
    do_reset("ra.rst");
    cycle("ra.cap", 1'b1, 8'h77, 8'(PORT_ID), 1'b0);
    check("ra.in_ack", 32'(data_rd), 32'h1);
    #1;
    do_reset("ra.mid");
    check("ra.count", 32'(count), 32'h0);

`ifdef XSWITCH_RX_ADDR_CHECK_EN
    // Misaddressed words are acknowledged, not stored, and counted with saturation.
    cycle("ae.cap", 1'b1, 8'h99, 8'h01, 1'b0);
    check("ae.ack", 32'(data_rd), 32'h1);
    check("ae.count", 32'(count), 32'h0);
    check("ae.err1", 32'(err_cnt), 32'h1);
    cycle("ae.ackcyc", 1'b1, 8'h99, 8'h01, 1'b0);
    for (int k = 0; k < 299; k++) begin
      cycle("ae.sat", 1'b1, 8'(k), 8'h01, 1'b0);
      cycle("ae.sat", 1'b1, 8'(k), 8'h01, 1'b0);
    end
    check("ae.err255", 32'(err_cnt), 32'hFF);
`else
    // Without the address check every word is stored and err_cnt stays 0.
    cycle("na.cap", 1'b1, 8'h99, 8'h01, 1'b0);
    check("na.count", 32'(count), 32'h1);
    check("na.addr", 32'(rd_addr), 32'h01);
    check("na.err0", 32'(err_cnt), 32'h0);
    cycle("na.ackcyc", 1'b0, 8'h00, 8'h00, 1'b1);
`endif

    // Random traffic; the switch holds each word until it is acknowledged.
    do_reset("rnd.rst");
    have = 1'b0;
    hd   = 8'h00;
    ha   = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      int   pp;
      logic p;
      pp = (i < 500) ? 6 : ((i < 1000) ? 2 : 1);
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        hd   = 8'($urandom);
        ha   = ($urandom_range(0, 3) != 0) ? 8'(PORT_ID) : 8'($urandom);
      end
      p = ($urandom_range(0, pp - 1) == 0);
      if (have) cycle("rnd", 1'b1, hd, ha, p);
      else      cycle("rnd", 1'b0, 8'($urandom), 8'($urandom), p);
      if (m_ack) have = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
